uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Parametrised UART transmitter: next generation of our fixed 8N1 sender.
//  Configurable data width, parity and stop bits, exact per-bit timing, and a
//  small input FIFO behind a valid/ready handshake, so producers (display
//  controller, debug logic) can queue bytes without polling for idle.
//  Drives the board TX pin directly.
// PARAMETERS
//  CLOCK_SPEED_MHZ  100   system clock frequency, MHz
//  BAUD_RATE        9600  line rate, bit/s
//  DATA_BITS        8     payload bits per frame, legal 5..9
//  PARITY           0     0 none, 1 odd, 2 even
//  STOP_BITS        1     1 or 2
//  FIFO_DEPTH       4     input FIFO entries, power of 2, >=2
// PORTS
//  clk         in   1                      system clock, all logic on posedge
//  rst_n       in   1                      asynchronous reset, active low
//  in_data     in   DATA_BITS              word to send
//  in_valid    in   1                      in_data valid this cycle
//  in_ready    out  1                      FIFO can accept (== !full)
//  tx          out  1                      serial line, idle high, registered
//  busy        out  1                      frame in progress or FIFO non-empty
//  fifo_count  out  $clog2(FIFO_DEPTH+1)   words queued, not incl. one on line
// BEHAVIOUR
//  - CYCLES_PER_BIT = CLOCK_SPEED_MHZ*1e6/BAUD_RATE (integer, truncated); every
//    line bit held exactly CYCLES_PER_BIT clocks. Counter width
//    $clog2(CYCLES_PER_BIT+1).
//  - Reset (async, rst_n=0): tx=1, busy=0, fifo_count=0, in_ready=1, FSM=IDLE,
//    FIFO pointers cleared. Reset mid-frame aborts the frame; tx high at once.
//  - Push: in_valid && in_ready at posedge writes in_data. in_valid while
//    in_ready=0 is ignored (word dropped); in_data need not be held after push.
//  - in_ready computed from full only: no push when full even if a pop occurs
//    in the same cycle. Push + pop in same cycle when not full: count unchanged.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
//    IDLE: tx=1; if FIFO non-empty, pop head into shift reg, go START.
//    START: tx=0 for one bit time.
//    DATA: DATA_BITS bits, LSB first, bit index 0..DATA_BITS-1.
//    PARITY (only if PARITY!=0): odd -> tx=~^word, even -> tx=^word.
//    STOP: tx=1 for STOP_BITS bit times; at end, if FIFO non-empty pop and go
//    straight to START (no idle gap), else IDLE.
//  - Latency: push at edge t into empty FIFO with FSM IDLE -> pop at edge t+1,
//    tx falls at edge t+2.
//  - Frame length = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CYCLES_PER_BIT clocks.
//  - busy = (FSM!=IDLE) || (fifo_count!=0); deasserts same edge tx returns to
//    idle after the last stop bit.
//  - FIFO pointers wrap modulo FIFO_DEPTH; full/empty from count.
// TESTING  (bench uses CLOCK_SPEED_MHZ=1, BAUD_RATE=100000 -> 10 clk/bit)
//  1 8N1: push 8'hA5 at t -> tx low at t+2 for 10 clk, then bits
//    1,0,1,0,0,1,0,1 (10 clk each), stop high 10 clk; busy low after 100 clk.
//  2 PARITY=2, DATA_BITS=7: push 7'h55 -> parity bit 0 after data; PARITY=1
//    same word -> parity 1; frame 100 clk.
//  3 STOP_BITS=2: push two words back-to-back -> second start bit follows
//    exactly 20 clk of high after last data bit; no extra idle cycle.
//  4 Fill: hold in_valid for 6 cycles from idle, FIFO_DEPTH=4 -> 5 words
//    accepted (1 popped), in_ready low from 6th; 6th word dropped; 5 frames
//    on line in order.
//  5 Reset mid-frame: assert rst_n=0 during DATA bit 3 -> tx=1, busy=0,
//    fifo_count=0 immediately; after release, push 8'h3C -> clean frame.
//  6 Decoder check: bench UART receiver samples mid-bit over 256 random words
//    at DATA_BITS 5..9, all parity modes -> zero mismatches/parity errors.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable framing and a small input FIFO.
// Line timing is exact: every bit is held for CYCLES_PER_BIT clocks.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int CLOCK_SPEED_MHZ = 100,
  parameter int BAUD_RATE       = 9600,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [DATA_BITS-1:0]               in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic                               tx,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int CPB = CLOCK_SPEED_MHZ * 1000000 / BAUD_RATE;
  localparam int CW  = $clog2(CPB + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int NW  = $clog2(FIFO_DEPTH + 1);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [NW-1:0]        count;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par;
  logic                 bit_end;
  logic                 stop_last;

  assign full       = (count == NW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign in_ready   = !full;
  assign fifo_count = count;
  assign push       = in_valid && !full;
  assign head       = mem[rd_ptr];
  assign head_par   = (PARITY == 1) ? ~^head : ^head;
  assign bit_end    = (cnt == LAST);
  assign stop_last  = (stop_idx == 1'(STOP_BITS - 1));

  // Pop on idle, or back-to-back at the end of the last stop bit.
  assign pop = !empty && ((state == IDLE) ||
               (state == STOP && bit_end && stop_last));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  // tx lags the state by one clock so every bit, including start, is CPB long.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par      <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      busy <= push || !empty || (state != IDLE);
      if (state == IDLE) cnt <= '0;
      else cnt <= bit_end ? '0 : cnt + CW'(1);
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shreg <= head;
            par   <= head_par;
            state <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (bit_end) begin
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          tx <= shreg[0];
          if (bit_end) begin
            shreg <= shreg >> 1;
            if (bit_idx == BW'(DATA_BITS - 1)) begin
              stop_idx <= 1'b0;
              state    <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end
        PAR: begin
          tx <= par;
          if (bit_end) begin
            stop_idx <= 1'b0;
            state    <= STOP;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            if (!stop_last) begin
              stop_idx <= 1'b1;
            end else if (pop) begin
              shreg <= head;
              par   <= head_par;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: seven framing variants at 10 clocks per bit,
// checked cycle-by-cycle against a frame model and by a mid-bit receiver.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  function automatic int db(int g);
    case (g)
      1, 2:    return 7;
      4:       return 5;
      5:       return 9;
      6:       return 6;
      default: return 8;
    endcase
  endfunction

  function automatic int pa(int g);
    case (g)
      1, 5:    return 2;
      2, 4:    return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int sb(int g);
    case (g)
      3, 5:    return 2;
      default: return 1;
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] din = '0;
  logic [6:0] vld = '0;
  logic [6:0] rdy;
  logic [6:0] txv;
  logic [6:0] bsy;
  logic [2:0] cnt [7];

  int ncmp = 0;
  int nbad = 0;

  logic [8:0] sw [8];
  logic       sp [8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 7; g++) begin : gd
    localparam int W = db(g);
    uart_tx_fifo #(
      .CLOCK_SPEED_MHZ(1),
      .BAUD_RATE(100000),
      .DATA_BITS(W),
      .PARITY(pa(g)),
      .STOP_BITS(sb(g)),
      .FIFO_DEPTH(4)
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_data(din[W-1:0]),
      .in_valid(vld[g]),
      .in_ready(rdy[g]),
      .tx(txv[g]),
      .busy(bsy[g]),
      .fifo_count(cnt[g])
    );
  end

  typedef struct {
    int         g;
    logic [8:0] w;
    logic       pb;
    string      nm;
  } vec_t;

  vec_t tv [12];

  task automatic chk(string nm, int act, int exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int flen(int g);
    return 1 + db(g) + ((pa(g) != 0) ? 1 : 0) + sb(g);
  endfunction

  function automatic logic [12:0] fbits(int g, logic [8:0] w, logic pb);
    logic [12:0] f;
    int k;
    f = '1;
    f[0] = 1'b0;
    k = 1;
    for (int i = 0; i < db(g); i++) begin
      f[k] = w[i];
      k++;
    end
    if (pa(g) != 0) f[k] = pb;
    return f;
  endfunction

  function automatic logic mpar(int g, logic [8:0] w);
    logic [8:0] m;
    m = w & 9'((1 << db(g)) - 1);
    return (pa(g) == 1) ? ~^m : ^m;
  endfunction

  task automatic push1(int g, logic [8:0] w);
    @(negedge clk);
    din = w;
    vld[g] = 1'b1;
    @(posedge clk);
    #1 vld[g] = 1'b0;
  endtask

  // Called right after the first push edge t; expects tx to fall at t+2.
  task automatic check_stream(int g, int n, string nm);
    int errs;
    logic [12:0] fb;
    errs = 0;
    @(negedge clk);
    @(negedge clk);
    if (txv[g] !== 1'b1) errs++;
    for (int f = 0; f < n; f++) begin
      fb = fbits(g, sw[f], sp[f]);
      for (int b = 0; b < flen(g); b++) begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (txv[g] !== fb[b] || bsy[g] !== 1'b1) errs++;
        end
      end
    end
    chk({nm, "_line"}, errs, 0);
    @(negedge clk);
    chk({nm, "_idle"}, int'({bsy[g], txv[g]}), 1);
  endtask

  task automatic rx(int g, output logic [8:0] d, output bit ok);
    int k;
    logic p;
    ok = 1'b1;
    d = '0;
    k = 0;
    while (txv[g] !== 1'b0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      ok = 1'b0;
      return;
    end
    repeat (4) @(negedge clk);
    if (txv[g] !== 1'b0) ok = 1'b0;
    for (int i = 0; i < db(g); i++) begin
      repeat (10) @(negedge clk);
      d[i] = txv[g];
    end
    if (pa(g) != 0) begin
      repeat (10) @(negedge clk);
      p = txv[g];
      if ((pa(g) == 1) && ((^d ^ p) !== 1'b1)) ok = 1'b0;
      if ((pa(g) == 2) && ((^d ^ p) !== 1'b0)) ok = 1'b0;
    end
    for (int s = 0; s < sb(g); s++) begin
      repeat (10) @(negedge clk);
      if (txv[g] !== 1'b1) ok = 1'b0;
    end
  endtask

  initial begin
    logic [8:0] w6 [6];
    logic [8:0] d;
    logic [8:0] w;
    bit ok;
    int g;

    tv[0]  = '{0, 9'h0A5, 1'b0, "a5_8n1"};
    tv[1]  = '{0, 9'h000, 1'b0, "00_8n1"};
    tv[2]  = '{0, 9'h0FF, 1'b0, "ff_8n1"};
    tv[3]  = '{1, 9'h055, 1'b0, "55_7e1"};
    tv[4]  = '{2, 9'h055, 1'b1, "55_7o1"};
    tv[5]  = '{1, 9'h001, 1'b1, "01_7e1"};
    tv[6]  = '{2, 9'h001, 1'b0, "01_7o1"};
    tv[7]  = '{3, 9'h03C, 1'b0, "3c_8n2"};
    tv[8]  = '{4, 9'h01F, 1'b0, "1f_5o1"};
    tv[9]  = '{5, 9'h1FF, 1'b1, "1ff_9e2"};
    tv[10] = '{5, 9'h100, 1'b1, "100_9e2"};
    tv[11] = '{6, 9'h02A, 1'b0, "2a_6n1"};

    repeat (3) @(negedge clk);
    chk("rst_tx", int'(txv), 'h7F);
    chk("rst_busy", int'(bsy), 0);
    chk("rst_ready", int'(rdy), 'h7F);
    chk("rst_count", int'(cnt[0]), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      sw[0] = tv[i].w;
      sp[0] = tv[i].pb;
      push1(tv[i].g, tv[i].w);
      check_stream(tv[i].g, 1, tv[i].nm);
    end

    sw[0] = 9'h0C6;
    sw[1] = 9'h039;
    sp[0] = 1'b0;
    sp[1] = 1'b0;
    @(negedge clk);
    din = sw[0];
    vld[3] = 1'b1;
    @(posedge clk);
    fork
      begin
        @(negedge clk);
        din = sw[1];
        @(posedge clk);
        #1 vld[3] = 1'b0;
      end
      check_stream(3, 2, "stop2_b2b");
    join

    w6[0] = 9'h11;
    w6[1] = 9'h22;
    w6[2] = 9'h33;
    w6[3] = 9'h44;
    w6[4] = 9'h55;
    w6[5] = 9'h66;
    for (int i = 0; i < 5; i++) begin
      sw[i] = w6[i];
      sp[i] = 1'b0;
    end
    @(negedge clk);
    din = w6[0];
    vld[0] = 1'b1;
    @(posedge clk);
    fork
      begin
        for (int k = 1; k < 6; k++) begin
          @(negedge clk);
          din = w6[k];
          if (k == 1) chk("fill_cnt1", int'(cnt[0]), 1);
          if (k == 5) begin
            chk("fill_ready", int'(rdy[0]), 0);
            chk("fill_cnt4", int'(cnt[0]), 4);
          end
        end
        @(negedge clk);
        vld[0] = 1'b0;
        chk("fill_drop", int'(cnt[0]), 4);
      end
      check_stream(0, 5, "fill");
    join

    push1(0, 9'h0C3);
    push1(0, 9'h081);
    repeat (45) @(negedge clk);
    chk("pre_rst_count", int'(cnt[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", int'(txv[0]), 1);
    chk("mid_rst_busy", int'(bsy[0]), 0);
    chk("mid_rst_count", int'(cnt[0]), 0);
    chk("mid_rst_ready", int'(rdy[0]), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    sw[0] = 9'h03C;
    sp[0] = 1'b0;
    push1(0, 9'h03C);
    check_stream(0, 1, "post_rst");

    sw[0] = 9'h0B7;
    sp[0] = mpar(4, 9'h0B7);
    push1(4, 9'h0B7);
    check_stream(4, 1, "model_5o1");

    for (int i = 0; i < 256; i++) begin
      g = i % 7;
      w = 9'($urandom) & 9'((1 << db(g)) - 1);
      push1(g, w);
      rx(g, d, ok);
      chk("rx_word", int'({ok, d}), int'({1'b1, w}));
    end

    repeat (200) @(negedge clk);
    chk("end_idle", int'({bsy, txv}), 'h7F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
